// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller bundle between pipeline and controller
//
// Purpose: carries the ID-stage source/destination descriptor, the per-stage
// stall/flush requests, and the enables, valids and forwarding selects returned
// by the controller.
// Modports:
//   master - pipeline side: drives id_*, stall_req, flush, flush_stage;
//            receives stage_en, stage_valid, fwd_rs_sel, fwd_rt_sel, hazard_stall
//   slave  - controller side (pipe_hazard_ctrl)
interface pipe_hazard_ctrl_if #(
    parameter int STAGES = 5,
    parameter int REG_W  = 5
);
    logic              id_valid;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wen;
    logic [REG_W-1:0]  id_dest;
    logic              id_is_load;
    logic [STAGES-1:0] stall_req;
    logic              flush;
    logic [2:0]        flush_stage;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_valid;
    logic [2:0]        fwd_rs_sel;
    logic [2:0]        fwd_rt_sel;
    logic              hazard_stall;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_wen, id_dest, id_is_load,
        output stall_req, flush, flush_stage,
        input  stage_en, stage_valid, fwd_rs_sel, fwd_rt_sel, hazard_stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_wen, id_dest, id_is_load,
        input  stall_req, flush, flush_stage,
        output stage_en, stage_valid, fwd_rs_sel, fwd_rt_sel, hazard_stall
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall, flush, bubble and forwarding controller
//
// Purpose: tracks valid/destination state of every pipeline stage, derives the
// per-stage register enables from stall requests and the load-use interlock,
// inserts bubbles behind frozen stages, kills stages on flush and picks the
// youngest in-flight producer for each ID source operand.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - pipe_hazard_ctrl_if.slave (ID descriptor, stall/flush in;
//              stage_en, stage_valid, fwd_rs_sel, fwd_rt_sel, hazard_stall out)
// Build option: PIPE_HAZARD_FWD_EN enables forwarding; without it every RAW
// dependency on an in-flight producer interlocks until the producer retires.
module pipe_hazard_ctrl #(
    parameter int STAGES     = 5,
    parameter int REG_W      = 5,
    parameter int LOAD_READY = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // Stage tracker; destination descriptors exist only for stages 2..STAGES-1
    logic [STAGES-1:0] v;
    logic [STAGES-1:2] wen;
    logic [STAGES-1:2] ld;
    logic [REG_W-1:0]  dest [2:STAGES-1];

    // What each stage would load when it advances
    logic [STAGES-1:1] src_v;
    logic [STAGES-1:2] src_wen;
    logic [STAGES-1:2] src_ld;
    logic [REG_W-1:0]  src_dest [2:STAGES-1];

    logic [STAGES-1:0] frz;
    logic              stall_acc;
    logic [STAGES-1:2] match_rs;
    logic [STAGES-1:2] match_rt;
    logic [2:0]        rs_sel;
    logic [2:0]        rt_sel;
    logic              rs_late;   // chosen rs producer is a load not yet forwardable
    logic              rt_late;
    logic              any_match;
    logic              hazard;

    for (genvar k = 1; k < STAGES; k++) begin : g_src
        if (k == 1) begin : g_id
            assign src_v[k] = bus.id_valid;
        end else begin : g_trk
            assign src_v[k] = v[k-1];
            assign match_rs[k] = v[k] & wen[k] & (dest[k] == bus.id_rs) &
                                 (bus.id_rs != '0) & bus.id_use_rs & bus.id_valid;
            assign match_rt[k] = v[k] & wen[k] & (dest[k] == bus.id_rt) &
                                 (bus.id_rt != '0) & bus.id_use_rt & bus.id_valid;
            if (k == 2) begin : g_first
                assign src_wen[k]  = bus.id_wen;
                assign src_ld[k]   = bus.id_is_load;
                assign src_dest[k] = bus.id_dest;
            end else begin : g_chain
                assign src_wen[k]  = wen[k-1];
                assign src_ld[k]   = ld[k-1];
                assign src_dest[k] = dest[k-1];
            end
        end
    end

    // Scan oldest to youngest so the youngest matching producer wins
    always_comb begin
        rs_sel  = '0;
        rt_sel  = '0;
        rs_late = 1'b0;
        rt_late = 1'b0;
        for (int k = STAGES - 1; k >= 2; k--) begin
            if (match_rs[k]) begin
                rs_sel  = 3'(k);
                rs_late = ld[k] && (k < LOAD_READY);
            end
            if (match_rt[k]) begin
                rt_sel  = 3'(k);
                rt_late = ld[k] && (k < LOAD_READY);
            end
        end
    end

    assign any_match = (|match_rs) | (|match_rt);
    assign hazard    = FWD_EN ? (rs_late | rt_late) : any_match;

    // A stall anywhere freezes that stage and everything younger
    always_comb begin
        frz       = '0;
        stall_acc = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            stall_acc = stall_acc | bus.stall_req[k];
            frz[k]    = stall_acc | ((k < 2) & hazard);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v   <= '0;
            wen <= '0;
            ld  <= '0;
            for (int k = 2; k < STAGES; k++) dest[k] <= '0;
        end else begin
            if (!frz[0]) v[0] <= 1'b1;
            for (int k = 1; k < STAGES; k++) begin
                if (!frz[k]) v[k] <= frz[k-1] ? 1'b0 : src_v[k];
            end
            for (int k = 2; k < STAGES; k++) begin
                if (!frz[k]) begin
                    wen[k]  <= frz[k-1] ? 1'b0 : src_wen[k];
                    ld[k]   <= src_ld[k];
                    dest[k] <= src_dest[k];
                end
            end
            // Kill comes last so it overrides both hold and shift; payload of a
            // killed stage is left as hold/shift produced it
            for (int k = 0; k < STAGES; k++) begin
                if (bus.flush && (k < int'(bus.flush_stage))) v[k] <= 1'b0;
            end
            for (int k = 2; k < STAGES; k++) begin
                if (bus.flush && (k < int'(bus.flush_stage))) wen[k] <= 1'b0;
            end
        end
    end

    assign bus.stage_en     = ~frz;
    assign bus.stage_valid  = v;
    assign bus.fwd_rs_sel   = FWD_EN ? rs_sel : 3'd0;
    assign bus.fwd_rt_sel   = FWD_EN ? rt_sel : 3'd0;
    assign bus.hazard_stall = hazard;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int S  = 5;
    localparam int W  = 5;
    localparam int LR = 4;

    typedef struct packed {
        logic         v;
        logic         wen;
        logic [W-1:0] dest;
        logic         ld;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.STAGES(S), .REG_W(W)) bus ();

    pipe_hazard_ctrl #(.STAGES(S), .REG_W(W), .LOAD_READY(LR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    ent_t         pipe [S];
    logic [S-1:0] e_en, e_v;
    logic [2:0]   e_rs, e_rt;
    logic         e_hz;
    int           top;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: nearest producer is the lowest tracked stage holding a valid write
    task automatic model_outputs();
        int rs_k, rt_k;
        rs_k = 0;
        rt_k = 0;
        for (int k = 2; k < S; k++) begin
            if (pipe[k].v && pipe[k].wen && bus.id_valid) begin
                if (rs_k == 0 && bus.id_use_rs && bus.id_rs != 0 && pipe[k].dest == bus.id_rs) rs_k = k;
                if (rt_k == 0 && bus.id_use_rt && bus.id_rt != 0 && pipe[k].dest == bus.id_rt) rt_k = k;
            end
        end
`ifdef PIPE_HAZARD_FWD_EN
        e_rs = 3'(rs_k);
        e_rt = 3'(rt_k);
        e_hz = (rs_k != 0 && pipe[rs_k].ld && rs_k < LR) || (rt_k != 0 && pipe[rt_k].ld && rt_k < LR);
`else
        e_rs = 3'd0;
        e_rt = 3'd0;
        e_hz = (rs_k != 0) || (rt_k != 0);
`endif
        // every stage at or below the highest frozen point holds
        top = -1;
        for (int j = 0; j < S; j++) if (bus.stall_req[j]) top = j;
        if (e_hz && top < 1) top = 1;
        for (int k = 0; k < S; k++) begin
            e_en[k] = (k > top);
            e_v[k]  = pipe[k].v;
        end
    endtask

    task automatic model_advance();
        ent_t nxt [S];
        int   fs;
        if (rst) begin
            for (int k = 0; k < S; k++) pipe[k] = '0;
            return;
        end
        nxt = pipe;
        for (int k = 0; k < S; k++) begin
            if (k > top) begin
                if (k == 0) nxt[0].v = 1'b1;
                else if (k - 1 <= top) begin
                    nxt[k].v   = 1'b0;
                    nxt[k].wen = 1'b0;
                end else if (k == 1) nxt[1].v = bus.id_valid;
                else if (k == 2) nxt[2] = '{v: pipe[1].v, wen: bus.id_wen, dest: bus.id_dest, ld: bus.id_is_load};
                else nxt[k] = pipe[k-1];
            end
        end
        fs = (int'(bus.flush_stage) > S) ? S : int'(bus.flush_stage);
        if (bus.flush) begin
            for (int k = 0; k < fs; k++) begin
                nxt[k].v   = 1'b0;
                nxt[k].wen = 1'b0;
            end
        end
        pipe = nxt;
    endtask

    task automatic sample();
        @(negedge clk);
        model_outputs();
        check_eq("stage_en", 32'(bus.stage_en), 32'(e_en));
        check_eq("stage_valid", 32'(bus.stage_valid), 32'(e_v));
        check_eq("fwd_rs_sel", 32'(bus.fwd_rs_sel), 32'(e_rs));
        check_eq("fwd_rt_sel", 32'(bus.fwd_rt_sel), 32'(e_rt));
        check_eq("hazard_stall", 32'(bus.hazard_stall), 32'(e_hz));
    endtask

    task automatic advance();
        model_outputs();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid    = 1'b0;
        bus.id_rs       = '0;
        bus.id_rt       = '0;
        bus.id_use_rs   = 1'b0;
        bus.id_use_rt   = 1'b0;
        bus.id_wen      = 1'b0;
        bus.id_dest     = '0;
        bus.id_is_load  = 1'b0;
        bus.stall_req   = '0;
        bus.flush       = 1'b0;
        bus.flush_stage = 3'd0;
    endtask

    task automatic set_id(input logic valid, input logic wen, input logic [W-1:0] dest,
                          input logic [W-1:0] rs, input logic use_rs);
        bus.id_valid  = valid;
        bus.id_wen    = wen;
        bus.id_dest   = dest;
        bus.id_rs     = rs;
        bus.id_use_rs = use_rs;
    endtask

    int hz_cycles;

    initial begin
        rst = 1'b1;
        idle_inputs();
        advance();
        rst = 1'b0;

        // reset state
        sample();
        check_eq("rst_valid", 32'(bus.stage_valid), 32'h0);
        check_eq("rst_en", 32'(bus.stage_en), 32'h1f);
        check_eq("rst_sel", 32'({bus.fwd_rs_sel, bus.fwd_rt_sel}), 32'h0);
        check_eq("rst_hz", 32'(bus.hazard_stall), 32'h0);
        advance();

        // ALU RAW: producer dest=5, consumer rs=5
        set_id(1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        sample(); advance();
        sample(); advance();
        set_id(1'b1, 1'b1, 5'd5, 5'd0, 1'b0);
        sample(); advance();
        set_id(1'b1, 1'b0, 5'd0, 5'd5, 1'b1);
`ifdef PIPE_HAZARD_FWD_EN
        sample();
        check_eq("raw_sel2", 32'(bus.fwd_rs_sel), 32'd2);
        check_eq("raw_nohz", 32'(bus.hazard_stall), 32'd0);
        advance();
        sample();
        check_eq("raw_sel3", 32'(bus.fwd_rs_sel), 32'd3);
        advance();
`else
        hz_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (!bus.hazard_stall) break;
            hz_cycles++;
            advance();
        end
        check_eq("nofwd_hz_cycles", 32'(hz_cycles), 32'd3);
        check_eq("nofwd_sel", 32'(bus.fwd_rs_sel), 32'd0);
        advance();
`endif

        // $zero destination never matches
        set_id(1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        sample(); advance();
        set_id(1'b1, 1'b0, 5'd0, 5'd0, 1'b1);
        sample();
        check_eq("zero_sel", 32'(bus.fwd_rs_sel), 32'd0);
        check_eq("zero_hz", 32'(bus.hazard_stall), 32'd0);
        advance();

        // stall at stage 3 together with flush below stage 2
        set_id(1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            sample(); advance();
        end
        set_id(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        bus.stall_req   = 5'b01000;
        bus.flush       = 1'b1;
        bus.flush_stage = 3'd2;
        sample();
        check_eq("sf_en", 32'(bus.stage_en), 32'h10);
        advance();
        idle_inputs();
        sample();
        check_eq("sf_v10", 32'(bus.stage_valid[1:0]), 32'd0);
        check_eq("sf_v3", 32'(bus.stage_valid[3]), 32'd1);
        check_eq("sf_v4", 32'(bus.stage_valid[4]), 32'd0);
        advance();

        // randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            bus.id_valid    = ($urandom_range(0, 9) < 8);
            bus.id_rs       = W'($urandom_range(0, 3));
            bus.id_rt       = W'($urandom_range(0, 3));
            bus.id_use_rs   = $urandom_range(0, 1) == 1;
            bus.id_use_rt   = $urandom_range(0, 1) == 1;
            bus.id_wen      = ($urandom_range(0, 3) != 0);
            bus.id_dest     = W'($urandom_range(0, 3));
            bus.id_is_load  = $urandom_range(0, 1) == 1;
            for (int j = 0; j < S; j++) bus.stall_req[j] = ($urandom_range(0, 11) == 0);
            bus.flush       = ($urandom_range(0, 14) == 0);
            bus.flush_stage = 3'($urandom_range(0, 7));
            sample();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
